fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipelined RV32I core; feeds the decode stage.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned words in a small prefetch FIFO; presents {pc, instr} to decode with valid/ready.
- Handles branch/jump redirects, discarding in-flight responses from the wrong path.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- DEPTH, 2, prefetch FIFO entries; also the cap on in-flight requests plus buffered entries (power of 2, min 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- redirect_valid  in  1  branch/jump taken from EX; squash and refetch.
- redirect_pc  in  XLEN  new fetch target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word address of the request.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, latency >= 1.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  {id_pc, id_instr} valid to decode.
- id_ready  in  1  decode accepts; 0 = hazard stall.
- id_pc  out  XLEN  PC of the presented instruction.
- id_instr  out  32  presented instruction.
- fetch_pc  out  XLEN  current fetch PC (debug/bench).

Behaviour:
- Reset (rst=0, async):
  - pc_q = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - imem_req = 0; id_valid = 0; id_pc = 0; id_instr = 32'h0000_0013 (NOP).
- Credit rule: imem_req = (outstanding + fifo_count < DEPTH) && !redirect_valid. Pushes therefore never overflow.
- Request handshake:
  - imem_addr = pc_q.
  - imem_addr must stay stable while imem_req && !imem_gnt.
  - On req && gnt: pc_q += 4 (wraps modulo 2^XLEN); outstanding++; the issued PC is pushed into an internal in-flight PC queue of DEPTH entries.
- Response handling (imem_rvalid):
  - outstanding--; pop the in-flight PC.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: push {pc, rdata} into the FIFO.
  - rvalid with outstanding == 0 is a protocol violation: ignored, and flagged by an assertion.
- Decode side:
  - id_valid = FIFO non-empty && !redirect_valid.
  - Pop on id_valid && id_ready.
  - Push and pop in the same cycle are both allowed.
  - id_pc/id_instr = FIFO head, held stable while id_valid && !id_ready.
- Redirect (highest priority):
  - Next cycle: pc_q = {redirect_pc[XLEN-1:2], 2'b00}; FIFO flushed.
  - discard = outstanding after this cycle's issue/return accounting (a response arriving in the redirect cycle is itself dropped).
  - imem_req = 0 and id_valid = 0 during the redirect cycle.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Latency: redirect to first request 1 cycle. With a 1-cycle memory, request to id_valid is 2 cycles; sustained throughput is 1 instr/cycle when DEPTH >= 2.
- Reset mid-operation clears all state. The memory side must also drop pending responses.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds output ports:
  - perf_fetched (32): count of instructions popped to decode.
  - perf_squashed (32): count of words discarded or flushed.
  - perf_stall (32): cycles with id_valid && !id_ready.
  - All three are saturating, reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - XLEN_DEF = 32.
  - NOP_INSTR = 32'h0000_0013.
  - typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with flush, count, and simultaneous push/pop.
- fetch_stage instantiates fetch_fifo twice: once for the instruction buffer and once for in-flight PCs (instr field unused).

Test Plan:
- Sequential fetch: 1-cycle memory, gnt=1, id_ready=1, rst released at 20ns.
  - Expected: id_pc sequence 0x0, 0x4, 0x8, ... on consecutive cycles; id_instr matches memory words.
- Decode stall: id_ready=0 for 5 cycles at PC 0x8.
  - Expected: id_pc/id_instr held at 0x8; imem_req drops once outstanding + count = 2; no PC skipped after release.
- Redirect with 2 in flight: memory latency 3, redirect_pc=0x100 while 0x8 and 0xC are outstanding.
  - Expected: both responses dropped; the next id_valid shows id_pc=0x100.
- Unaligned redirect: redirect_pc=0x203.
  - Expected: fetch_pc=0x200 next cycle.
- Memory back-pressure: imem_gnt=0 for 4 cycles.
  - Expected: imem_addr stable; pc_q unchanged; no duplicate or lost instruction.
- Async reset mid-burst: rst=0 asynchronously between edges.
  - Expected: outputs go to reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types, constants and helpers for the RV32I instruction-fetch stage.
`timescale 1ns/1ps
package fetch_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

  // Saturating 32-bit add used by the optional performance counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response and decode handshake bundle of the fetch stage.
`timescale 1ns/1ps
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO of fetch entries with flush, occupancy count and same-cycle push/pop.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC ownership, credit-limited imem requests, prefetch buffer, redirects.
// Optional performance counters are built when FETCH_PERF_EN is defined.
`timescale 1ns/1ps
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  fetch_stage_if.master     bus,
  output logic [XLEN-1:0]   fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed,
  output logic [31:0]       perf_stall
`endif
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [CNT_W-1:0] discard_q;
  logic [CNT_W-1:0] discard_d;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   in_use;
  logic             buf_empty;
  logic             pend_empty;
  logic             issue;
  logic             resp_ok;
  logic             resp_keep;
  logic             buf_pop;
  fetch_entry_t     buf_head;
  fetch_entry_t     buf_push_data;
  fetch_entry_t     pend_head;
  fetch_entry_t     pend_push_data;
  logic             pend_instr_unused;

  // Every issued-but-unanswered request and every buffered word holds one credit.
  assign in_use        = {1'b0, outstanding} + {1'b0, buf_count};
  assign bus.imem_req  = rst && (in_use < CREDITS) && !redirect_valid;
  assign bus.imem_addr = pc_q;
  assign issue         = bus.imem_req && bus.imem_gnt;

  assign resp_ok   = bus.imem_rvalid && !pend_empty;
  assign resp_keep = resp_ok && (discard_q == '0) && !redirect_valid;

  assign bus.id_valid = !buf_empty && !redirect_valid;
  assign bus.id_pc    = buf_empty ? '0 : buf_head.pc;
  assign bus.id_instr = buf_empty ? NOP_INSTR : buf_head.instr;
  assign buf_pop      = bus.id_valid && bus.id_ready;
  assign fetch_pc     = pc_q;

  assign buf_push_data  = '{pc: pend_head.pc, instr: bus.imem_rdata};
  assign pend_push_data = '{pc: pc_q, instr: NOP_INSTR};
  assign pend_instr_unused = ^pend_head.instr;

  // A redirect marks every request still in the air (after this cycle's return) as wrong-path.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d = outstanding - CNT_W'(resp_ok);
    end else begin
      if (issue) pc_d = pc_q + XLEN'(4);
      if (resp_ok && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  // In-flight PC queue: never flushed, since wrong-path responses still return and must be paired.
  fetch_fifo #(.DEPTH(DEPTH)) u_pend_pc (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (issue),
    .push_data (pend_push_data),
    .pop       (resp_ok),
    .head      (pend_head),
    .count     (outstanding),
    .empty     (pend_empty)
  );

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst) bus.imem_rvalid |-> !pend_empty
  );

`ifdef FETCH_PERF_EN
  logic [31:0] squash_now;

  always_comb begin
    squash_now = '0;
    if (resp_ok && ((discard_q != '0) || redirect_valid)) squash_now = 32'd1;
    if (redirect_valid) squash_now = squash_now + 32'(buf_count);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
      perf_stall    <= '0;
    end else begin
      perf_fetched  <= sat_add32(perf_fetched, 32'(buf_pop));
      perf_squashed <= sat_add32(perf_squashed, squash_now);
      perf_stall    <= sat_add32(perf_stall, 32'(bus.id_valid && !bus.id_ready));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order instruction stream, stalls, redirects, back-pressure, async reset.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mem_req_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic [XLEN-1:0] fetch_pc;
  logic            id_ready = 1'b0;
  logic            mem_gnt = 1'b1;
  int              mem_lat = 1;
  int              edge_no = 0;

  int              n_vec = 0;
  int              n_err = 0;

  mem_req_t        pend_q[$];
  exp_t            exp_q[$];
  exp_t            mon_e;
  logic            prev_stall = 1'b0;
  logic [XLEN-1:0] prev_addr = '0;

  fetch_stage_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
  logic [31:0] perf_stall;
`endif

  fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_pc       (fetch_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed),
    .perf_stall     (perf_stall)
`endif
  );

  assign bus.imem_gnt = mem_gnt;
  assign bus.id_ready = id_ready;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // In-order memory with programmable latency; pending responses vanish on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      edge_no++;
      if (bus.imem_req && bus.imem_gnt)
        pend_q.push_back('{addr: bus.imem_addr, due: edge_no + mem_lat - 1});
      if (pend_q.size() > 0 && pend_q[0].due <= edge_no) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        bus.imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_vec++;
    if (actual !== required) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [XLEN-1:0] start_pc, input int count);
    logic [XLEN-1:0] pc;
    for (int i = 0; i < count; i++) begin
      pc = start_pc + XLEN'(4 * i);
      exp_q.push_back('{pc: pc, instr: mem_word(pc)});
    end
  endtask

  // Called just after a rising edge; holds the redirect for exactly one cycle.
  task automatic pulse_redirect(input logic [XLEN-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    checkOutput("redirect_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("redirect_imem_req", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    checkOutput("redirect_fetch_pc", fetch_pc, {target[XLEN-1:2], 2'b00});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops the expected stream on every decode handshake and watches request stability.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_output: got pc=%h instr=%h, required no output",
                   bus.id_pc, bus.id_instr);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("id_pc", bus.id_pc, mon_e.pc);
          checkOutput("id_instr", bus.id_instr, mon_e.instr);
        end
      end
      if (prev_stall && bus.imem_req)
        checkOutput("imem_addr_stable", bus.imem_addr, prev_addr);
      prev_stall = bus.imem_req && !bus.imem_gnt;
      prev_addr  = bus.imem_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    #1 rst = 1'b0;
    #11;
    checkOutput("reset_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("reset_id_pc", bus.id_pc, 32'h0);
    checkOutput("reset_id_instr", bus.id_instr, NOP_INSTR);
    checkOutput("reset_fetch_pc", fetch_pc, 32'h0);

    $display("[TB] sequential fetch with decode stall at 0x8");
    applyStimulus(32'h0, 16);
    id_ready = 1'b1;
    #8 rst = 1'b1;
    @(posedge clk); #1;
    k = 0;
    while (!(bus.id_valid && bus.id_pc == 32'h8) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("stall_reached_pc", bus.id_pc, 32'h8);
    id_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_hold_pc", bus.id_pc, 32'h8);
      checkOutput("stall_hold_instr", bus.id_instr, mem_word(32'h8));
    end
    checkOutput("stall_req_dropped", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #1;
    id_ready = 1'b1;
    wait_drain("sequential", 200);
    id_ready = 1'b0;

    $display("[TB] redirect with two requests in flight");
    mem_lat = 3;
    applyStimulus(32'h0, 2);
    pulse_redirect(32'h0);
    id_ready = 1'b1;
    k = 0;
    while (!(pend_q.size() == 2 && pend_q[0].addr == 32'h8 && pend_q[1].addr == 32'hC &&
             !bus.imem_rvalid) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("inflight_count", 32'(pend_q.size()), 32'd2);
    applyStimulus(32'h100, 4);
    pulse_redirect(32'h100);
    wait_drain("redirect", 200);
    id_ready = 1'b0;

    $display("[TB] back-to-back unaligned redirect, then memory back-pressure");
    applyStimulus(32'h200, 16);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(posedge clk); #1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    checkOutput("b2b_id_valid", 32'(bus.id_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    checkOutput("b2b_fetch_pc", fetch_pc, 32'h200);
    mem_lat  = 1;
    id_ready = 1'b1;
    k = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'h210) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("bp_reached_addr", bus.imem_addr, 32'h210);
    mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("bp_addr", bus.imem_addr, 32'h210);
      checkOutput("bp_fetch_pc", fetch_pc, 32'h210);
    end
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    wait_drain("backpressure", 200);
    id_ready = 1'b0;

    $display("[TB] asynchronous reset mid-burst");
    mem_lat = 3;
    pulse_redirect(32'h400);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("midreset_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("midreset_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("midreset_id_pc", bus.id_pc, 32'h0);
    checkOutput("midreset_id_instr", bus.id_instr, NOP_INSTR);
    checkOutput("midreset_fetch_pc", fetch_pc, 32'h0);
    applyStimulus(32'h0, 8);
    mem_lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    id_ready = 1'b1;
    @(posedge clk); #1;
    wait_drain("post_reset", 200);
    id_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
